csa_resolve_seq: RTL and testbench
==================================

# csa_resolve_seq

Sequential carry-propagate resolver that converts the redundant sum/carry vector pair from the multiplier's 3:2 partial-product reduction tree into one binary result. It adds the two vectors CHUNK bits per cycle with a registered carry, trading latency for a short carry chain. It sits between the last compressor stage and mantissa normalisation/rounding. It uses a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 30, width of each input vector (sum and carry).
- CHUNK, 8, bits resolved per ADD cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam) = ceil(WIDTH/CHUNK); 4 with defaults.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_sum  in  WIDTH  sum vector from the reduction tree.
- in_carry  in  WIDTH  carry vector, already left-shifted by the tree (bit 0 normally 0; any value must be accepted).
- in_valid  in  1  input vectors valid.
- in_ready  out  1  block can accept; high only in IDLE.
- out_result  out  WIDTH+1  in_sum + in_carry, zero-extended; bit WIDTH is the final carry-out.
- out_valid  out  1  out_result valid; high only in DONE.
- out_ready  in  1  downstream accepts out_result.
- busy  out  1  high in ADD or DONE.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, register in_sum and in_carry. Set chunk index k=0 and carry register c=0. Go to ADD.
- ADD:
  - Each edge computes {c', r} = sum[k*CHUNK +: w] + carry[k*CHUNK +: w] + c, where w = CHUNK, or WIDTH−(NCHUNK−1)*CHUNK for the last chunk (6 with defaults).
  - r is written into result bits [k*CHUNK +: w]. c takes c', and k increments.
  - On the edge processing k=NCHUNK−1, result[WIDTH] takes c'. Go to DONE.
- DONE:
  - out_valid=1, and out_result is held stable.
  - On an edge with out_ready=1, go to IDLE. out_result keeps its last value until the next completion.
- in_valid is ignored outside IDLE. Inputs are sampled only at the accept edge, so later changes have no effect.
- Arithmetic is unsigned modulo 2^(WIDTH+1). Overflow cannot occur.
- Reset (any state, including mid-ADD):
  - State goes to IDLE. k=0, c=0, and the captured vectors are cleared.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, out_result=0.
  - The in-flight operation is discarded. No partial result is ever presented.

## Timing
- Accept at edge E0. ADD occupies edges E1..E_NCHUNK.
- out_valid rises after edge E_NCHUNK (E4 with defaults), giving a latency of NCHUNK cycles from acceptance.
- With out_ready=1 while DONE, the handshake completes at E_NCHUNK+1. in_ready is high after that edge, and the next accept is at E_NCHUNK+2.
  - Minimum issue interval: NCHUNK+2 cycles (6 with defaults).
- in_ready, out_valid and busy are decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Back-pressure: DONE persists indefinitely while out_ready=0.
- CHUNK=WIDTH degenerates to a single ADD cycle (latency 1). Functionality is unchanged.

## Test plan
- Reset and carry ripple:
  - Stimulus: assert rst for 2 cycles, release, then present in_sum=30'h3FFFFFFF, in_carry=30'h00000001, in_valid=1.
  - Response: in_ready=1 after reset. out_result=31'h40000000, with out_valid rising exactly 4 edges after accept. The carry must cross every chunk boundary.
- Chunk-boundary carry:
  - Stimulus: in_sum=30'h000000FF, in_carry=30'h00000001.
  - Response: out_result=31'h00000100.
- Carry-out:
  - Stimulus: in_sum=30'h3FFFFFFF, in_carry=30'h3FFFFFFE.
  - Response: out_result=31'h7FFFFFFD, with bit 30 set.
- Back-pressure and ignored input:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, toggling in_valid with new data.
  - Response: out_result stable, out_valid=1, in_ready=0, new data ignored. After out_ready=1, the next accept is 2 edges later.
- Reset mid-ADD:
  - Stimulus: accept in_sum=30'h12345678, then assert rst after 2 ADD edges.
  - Response: immediately out_valid=0, busy=0, out_result=0. The next transaction in_sum=5, in_carry=6 yields 31'd11.
- Randomised back-to-back run:
  - Stimulus: 1000 random (sum, carry) pairs, with out_ready held at 1 and also randomly throttled.
  - Response: each result equals the reference model sum. The issue interval is never shorter than 6 cycles.

Source files
------------

// File: rtl/csa_resolve_seq.sv
// -----------------------------------------------------------------------------
// csa_resolve_seq
//
// Sequential carry-propagate resolver. Takes the redundant sum/carry pair
// produced by the multiplier's 3:2 reduction tree and adds them CHUNK bits
// per cycle, with the carry held in a register between chunks. This keeps the
// carry chain to CHUNK bits at the cost of NCHUNK cycles of latency.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_sum     sum vector from the reduction tree            [WIDTH]
//   in_carry   carry vector (already left-shifted)           [WIDTH]
//   in_valid   input pair valid
//   in_ready   block can accept (IDLE only)
//   out_result in_sum + in_carry, bit WIDTH is carry-out     [WIDTH+1]
//   out_valid  out_result valid (DONE only)
//   out_ready  downstream accepts out_result
//   busy       high while in ADD or DONE
// -----------------------------------------------------------------------------
module csa_resolve_seq #(
   parameter int WIDTH = 30,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH:0]   out_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   // Width of the final (possibly narrower) chunk.
   localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
   // Operands are zero-padded to a whole number of chunks so the chunk
   // select never runs off the end of the captured vectors.
   localparam int PAD_W  = NCHUNK * CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;

   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] carry_reg;
   logic [WIDTH:0]   acc_reg;      // working result, built chunk by chunk
   logic [WIDTH:0]   acc_next;
   logic [WIDTH:0]   result_reg;   // presented result, updated only on completion
   logic [KW-1:0]    k_reg;
   logic             c_reg;

   logic [PAD_W-1:0] sum_pad;
   logic [PAD_W-1:0] carry_pad;
   logic [CHUNK-1:0] op_sum;
   logic [CHUNK-1:0] op_carry;
   logic [CHUNK:0]   chunk_sum;
   logic             is_last;
   logic             c_next;

   // ------------------------------------------------------------------
   // Chunk adder
   // ------------------------------------------------------------------
   assign sum_pad   = PAD_W'(sum_reg);
   assign carry_pad = PAD_W'(carry_reg);

   assign op_sum    = sum_pad[k_reg * CHUNK +: CHUNK];
   assign op_carry  = carry_pad[k_reg * CHUNK +: CHUNK];

   assign chunk_sum = {1'b0, op_sum} + {1'b0, op_carry} + {{CHUNK{1'b0}}, c_reg};

   assign is_last   = (k_reg == KW'(NCHUNK - 1));

   // The padding above WIDTH is zero, so on the last chunk the true carry-out
   // sits at bit LAST_W of the chunk sum rather than at bit CHUNK.
   assign c_next    = is_last ? chunk_sum[LAST_W] : chunk_sum[CHUNK];

   // Next working result: only the slice selected by k changes; every other
   // slice holds. Each slice has its own fixed width, which lets the last
   // chunk be narrower than CHUNK without any out-of-range writes.
   generate
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
         localparam int LO = gi * CHUNK;
         localparam int W  = (gi == NCHUNK - 1) ? LAST_W : CHUNK;

         assign acc_next[LO +: W] = (k_reg == KW'(gi)) ? chunk_sum[W-1:0]
                                                       : acc_reg[LO +: W];
      end
   endgenerate

   assign acc_next[WIDTH] = is_last ? c_next : acc_reg[WIDTH];

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and state-decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = ST_ADD;
            end
         end
         ST_ADD: begin
            busy = 1'b1;
            if (is_last) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_reg    <= '0;
         carry_reg  <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         k_reg      <= '0;
         c_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  sum_reg   <= in_sum;
                  carry_reg <= in_carry;
                  k_reg     <= '0;
                  c_reg     <= 1'b0;
               end
            end
            ST_ADD: begin
               acc_reg <= acc_next;
               c_reg   <= c_next;
               if (is_last) begin
                  k_reg      <= '0;
                  // Publish only the finished sum; the previous result stays
                  // visible for the whole ADD phase.
                  result_reg <= acc_next;
               end else begin
                  k_reg <= k_reg + KW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_result = result_reg;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// -----------------------------------------------------------------------------
// tb_csa_resolve_seq
//
// Directed and randomised checks of csa_resolve_seq with default parameters
// (WIDTH=30, CHUNK=8, four ADD cycles). Inputs change and outputs are sampled
// 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_csa_resolve_seq;

   logic        clk;
   logic        rst;
   logic [29:0] in_sum;
   logic [29:0] in_carry;
   logic        in_valid;
   logic        in_ready;
   logic [30:0] out_result;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int n_checks;
   int n_fail;
   int cyc;

   csa_resolve_seq #(
      .WIDTH(30),
      .CHUNK(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_result(out_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog: the run ends well before this.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   // Issue one transaction, wait for completion, then hold out_ready low for
   // 'hold' cycles before completing the output handshake.
   task automatic run_txn(input logic [29:0] s, input logic [29:0] c, input int hold,
                          output logic [30:0] res, output int lat, output int acc_cyc);
      int w;
      in_sum   = s;
      in_carry = c;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out_result;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      $display("txn sum=%h carry=%h result=%h latency=%0d accept_cycle=%0d",
               s, c, res, lat, acc_cyc);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_sum = '0;
      in_carry = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_checks++;
      if (out_result !== 31'h0) begin
         n_fail++; $display("FAIL reset_out_result: got %h want 0", out_result);
      end
   endtask

   task automatic test_ripple();
      logic [30:0] res;
      int lat, ac;
      run_txn(30'h3FFFFFFF, 30'h00000001, 0, res, lat, ac);
      n_checks++;
      if (res !== 31'h40000000) begin
         n_fail++; $display("FAIL ripple_result: got %h want 40000000", res);
      end
      n_checks++;
      if (lat !== 4) begin
         n_fail++; $display("FAIL ripple_latency: got %0d want 4", lat);
      end
   endtask

   task automatic test_chunk_boundary();
      logic [30:0] res;
      int lat, ac;
      run_txn(30'h000000FF, 30'h00000001, 0, res, lat, ac);
      n_checks++;
      if (res !== 31'h00000100) begin
         n_fail++; $display("FAIL chunk_boundary_result: got %h want 00000100", res);
      end
   endtask

   task automatic test_carry_out();
      logic [30:0] res;
      int lat, ac;
      run_txn(30'h3FFFFFFF, 30'h3FFFFFFE, 0, res, lat, ac);
      n_checks++;
      if (res !== 31'h7FFFFFFD) begin
         n_fail++; $display("FAIL carry_out_result: got %h want 7FFFFFFD", res);
      end
      n_checks++;
      if (res[30] !== 1'b1) begin
         n_fail++; $display("FAIL carry_out_bit30: got %b want 1", res[30]);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      // Start a transaction and wait for DONE.
      in_sum   = 30'h0ABCDEF0;
      in_carry = 30'h01010101;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (lat !== 4) begin
         n_fail++; $display("FAIL bp_latency: got %0d want 4", lat);
      end
      // Stall for 5 cycles while offering new data.
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         in_sum   = 30'h00001111 * 30'(i + 1);
         in_carry = 30'h00000003;
         @(posedge clk); #1;
         n_checks++;
         if (out_result !== 31'h0BBDDFF1) begin
            n_fail++; $display("FAIL bp_result_stable[%0d]: got %h want 0BBDDFF1", i, out_result);
         end
         n_checks++;
         if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid);
         end
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready);
         end
      end
      // Release; keep new data on in_valid so it is accepted at the next edge.
      in_sum    = 30'd7;
      in_carry  = 30'd8;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_next_accept: got busy=%b in_ready=%b want 1 0", busy, in_ready);
      end
      // Previous result must stay visible while the new one is computed.
      n_checks++;
      if (out_result !== 31'h0BBDDFF1) begin
         n_fail++; $display("FAIL bp_hold_during_add: got %h want 0BBDDFF1", out_result);
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (out_result !== 31'd15 || lat !== 4) begin
         n_fail++; $display("FAIL bp_second_result: got %h lat %0d want 0000000f lat 4", out_result, lat);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      $display("txn backpressure result=%h stalled 5 cycles", 31'h0BBDDFF1);
   endtask

   task automatic test_reset_mid_add();
      logic [30:0] res;
      int lat, ac;
      in_sum   = 30'h12345678;
      in_carry = 30'h0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL midreset_ctrl: got out_valid=%b busy=%b in_ready=%b want 0 0 1",
                            out_valid, busy, in_ready);
      end
      n_checks++;
      if (out_result !== 31'h0) begin
         n_fail++; $display("FAIL midreset_result: got %h want 0", out_result);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_txn(30'd5, 30'd6, 0, res, lat, ac);
      n_checks++;
      if (res !== 31'd11 || lat !== 4) begin
         n_fail++; $display("FAIL midreset_next: got %h lat %0d want 0000000b lat 4", res, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [29:0] s, c;
      logic [30:0] exp_res, res;
      int lat, ac, prev_ac, hold;
      prev_ac = 0;
      for (int i = 0; i < 1000; i++) begin
         s = 30'($urandom);
         c = 30'($urandom);
         exp_res = {1'b0, s} + {1'b0, c};
         hold = (i < 500) ? 0 : int'($urandom_range(0, 3));
         run_txn(s, c, hold, res, lat, ac);
         n_checks++;
         if (res !== exp_res) begin
            n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", i, res, exp_res);
         end
         n_checks++;
         if (lat !== 4) begin
            n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want 4", i, lat);
         end
         if (i > 0) begin
            n_checks++;
            if (ac - prev_ac < 6) begin
               n_fail++; $display("FAIL b2b_interval[%0d]: got %0d want >= 6", i, ac - prev_ac);
            end
         end
         // With no stall the interval should be exactly the minimum.
         if (i > 0 && i < 500) begin
            n_checks++;
            if (ac - prev_ac !== 6) begin
               n_fail++; $display("FAIL b2b_min_interval[%0d]: got %0d want 6", i, ac - prev_ac);
            end
         end
         prev_ac = ac;
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_sum    = '0;
      in_carry  = '0;
      test_reset();
      test_ripple();
      test_chunk_boundary();
      test_carry_out();
      test_backpressure();
      test_reset_mid_add();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
